// File: rtl/i2c_bus_gen_if.sv
// I2C bus generator interface: host command handshake, results and the
// open-drain pad controls/levels.
// master: the generator itself (drives the bus, serves commands).
// slave:  the host sequencer plus pad/bus model on the other side.
interface i2c_bus_gen_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       rd_ack_in;
    logic       done;
    logic       err;
    logic [7:0] rd_data;
    logic       ack_rcvd;
    logic       bus_held;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    modport master (
        input  cmd_valid, cmd, wr_data, rd_ack_in, scl_in, sda_in,
        output cmd_ready, done, err, rd_data, ack_rcvd, bus_held, scl_oe, sda_oe
    );

    modport slave (
        output cmd_valid, cmd, wr_data, rd_ack_in, scl_in, sda_in,
        input  cmd_ready, done, err, rd_data, ack_rcvd, bus_held, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_bus_gen.sv
// Command-driven I2C master bit/byte generator: START, repeated START, STOP,
// 8-bit WRITE/READ with ACK on open-drain SCL/SDA, timed in quarter SCL
// periods of CLK_DIV system clocks.
// Optional: define I2C_GEN_STRETCH_EN to honour slave clock stretching in Q2.
module i2c_bus_gen #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic          clk,
    input  logic          reset,
    i2c_bus_gen_if.master bus
);
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STOP,
        S_BIT,
        S_ERR
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       q, q_n;
    logic [3:0]       bit_idx, bit_n;
    logic             op_rd, op_rd_n;
    logic             rack, rack_n;
    logic [7:0]       tx, tx_n;
    logic [7:0]       rx, rx_n;
    logic             ack_tmp, ack_tmp_n;
    logic [7:0]       rd_data, rd_data_n;
    logic             ack_rcvd, ack_rcvd_n;
    logic             bus_held, bus_held_n;
    logic             done, done_n;
    logic             err, err_n;
    logic             scl_oe, scl_n;
    logic             sda_oe, sda_n;
    logic             tick;
    logic             hold;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

`ifdef I2C_GEN_STRETCH_EN
    // A slave holding SCL low during Q2 freezes the quarter counter.
    assign hold = (q == 2'd2) && !bus.scl_in;
`else
    assign hold = 1'b0;
`endif

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.done      = done;
    assign bus.err       = err;
    assign bus.rd_data   = rd_data;
    assign bus.ack_rcvd  = ack_rcvd;
    assign bus.bus_held  = bus_held;
    assign bus.scl_oe    = scl_oe;
    assign bus.sda_oe    = sda_oe;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state, quarter sequencing and pin/result updates.
    // Pin values are registered at each quarter boundary, so the value for a
    // quarter is computed on the tick that ends the previous one. The done
    // cycle is spent in the operation state so cmd_ready rises one cycle later.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        q_n        = q;
        bit_n      = bit_idx;
        op_rd_n    = op_rd;
        rack_n     = rack;
        tx_n       = tx;
        rx_n       = rx;
        ack_tmp_n  = ack_tmp;
        rd_data_n  = rd_data;
        ack_rcvd_n = ack_rcvd;
        bus_held_n = bus_held;
        done_n     = 1'b0;
        err_n      = 1'b0;
        scl_n      = scl_oe;
        sda_n      = sda_oe;
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cnt_n = '0;
                    q_n   = '0;
                    bit_n = '0;
                    case (bus.cmd)
                        2'b00: begin
                            state_n = S_START;
                            sda_n   = 1'b0;
                        end
                        2'b01: begin
                            state_n = S_STOP;
                            scl_n   = 1'b1;
                            sda_n   = 1'b1;
                        end
                        default: begin
                            if (!bus_held) begin
                                state_n = S_ERR;
                                done_n  = 1'b1;
                                err_n   = 1'b1;
                            end else begin
                                state_n = S_BIT;
                                op_rd_n = bus.cmd[0];
                                rack_n  = bus.rd_ack_in;
                                tx_n    = bus.wr_data;
                                scl_n   = 1'b1;
                                sda_n   = bus.cmd[0] ? 1'b0 : ~bus.wr_data[7];
                            end
                        end
                    endcase
                end
            end
            S_ERR: state_n = S_IDLE;
            default: begin
                if (done) begin
                    state_n = S_IDLE;
                end else if (hold) begin
                    cnt_n = '0;
                end else if (!tick) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    q_n   = q + 2'd1;
                    case (state)
                        S_START: begin
                            case (q)
                                2'd0: scl_n = 1'b0;
                                2'd1: sda_n = 1'b1;
                                2'd2: scl_n = 1'b1;
                                default: begin
                                    done_n     = 1'b1;
                                    bus_held_n = 1'b1;
                                end
                            endcase
                        end
                        S_STOP: begin
                            case (q)
                                2'd0: scl_n = 1'b0;
                                2'd1: sda_n = 1'b0;
                                2'd2: ;
                                default: begin
                                    done_n     = 1'b1;
                                    bus_held_n = 1'b0;
                                end
                            endcase
                        end
                        default: begin
                            case (q)
                                2'd0: scl_n = 1'b0;
                                2'd1: ;
                                2'd2: begin
                                    if (op_rd && !bit_idx[3]) rx_n = {rx[6:0], bus.sda_in};
                                    if (!op_rd && bit_idx[3]) ack_tmp_n = bus.sda_in;
                                    scl_n = 1'b1;
                                end
                                default: begin
                                    if (bit_idx[3]) begin
                                        done_n = 1'b1;
                                        sda_n  = 1'b0;
                                        if (op_rd) rd_data_n  = rx;
                                        else       ack_rcvd_n = ack_tmp;
                                    end else begin
                                        bit_n = bit_idx + 4'd1;
                                        tx_n  = {tx[6:0], 1'b0};
                                        if (bit_idx == 4'd7) sda_n = op_rd ? ~rack : 1'b0;
                                        else                 sda_n = op_rd ? 1'b0 : ~tx[6];
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            q        <= '0;
            bit_idx  <= '0;
            op_rd    <= 1'b0;
            rack     <= 1'b0;
            tx       <= '0;
            rx       <= '0;
            ack_tmp  <= 1'b1;
            rd_data  <= '0;
            ack_rcvd <= 1'b1;
            bus_held <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            q        <= q_n;
            bit_idx  <= bit_n;
            op_rd    <= op_rd_n;
            rack     <= rack_n;
            tx       <= tx_n;
            rx       <= rx_n;
            ack_tmp  <= ack_tmp_n;
            rd_data  <= rd_data_n;
            ack_rcvd <= ack_rcvd_n;
            bus_held <= bus_held_n;
            done     <= done_n;
            err      <= err_n;
            scl_oe   <= scl_n;
            sda_oe   <= sda_n;
        end
    end
endmodule

// File: doc/i2c_bus_gen.md
Name: i2c_bus_gen

Overview:
- Command-driven I2C master bit/byte generator. It is the driving end of the bus that the start/stop analyzer watches.
- Produces START, repeated START, STOP and 8-bit WRITE/READ with ACK on open-drain SCL/SDA, timed from a single system clock.
- Sits between a host command FSM (or testbench sequencer) and the I2C pads. It is the stimulus source for analyzer bring-up.

Parameters:
- CLK_DIV, 250, clk cycles per quarter SCL period. SCL frequency = f_clk/(4*CLK_DIV). Legal range is 2 or more.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high when a command can be accepted (IDLE only)
- cmd  input  2  00=START, 01=STOP, 10=WRITE, 11=READ
- wr_data  input  8  byte for WRITE; sampled at acceptance
- rd_ack_in  input  1  ACK bit the master sends after READ (0=ACK, 1=NACK); sampled at acceptance
- done  output  1  one-cycle pulse when a command completes
- err  output  1  valid with done; 1 = WRITE/READ issued while bus not held
- rd_data  output  8  received byte; updated at READ done, held otherwise
- ack_rcvd  output  1  slave ACK bit sampled on WRITE (0=ACK); updated at WRITE done
- bus_held  output  1  set at START done, cleared at STOP done
- scl_oe  output  1  1 = pull SCL low
- sda_oe  output  1  1 = pull SDA low
- scl_in  input  1  SCL pad level
- sda_in  input  1  SDA pad level

Behaviour:
- Reset values (synchronous, dominates every other event, valid mid-command):
  - scl_oe=0, sda_oe=0 (bus released)
  - done=0, err=0, rd_data=0, ack_rcvd=1, bus_held=0
  - state=IDLE, cmd_ready=1, quarter counter=0
- Handshake: a command is accepted on a cycle with cmd_valid and cmd_ready both high. cmd_ready is low from the cycle after acceptance until the cycle after done. cmd is ignored while cmd_ready=0.
- Quarter tick: a counter runs 0..CLK_DIV-1 and a phase ends when it reaches CLK_DIV-1. Each operation is a sequence of quarters Q0..Q3.
- States: IDLE, START, STOP, BIT, ERR.
- START (repeated START is allowed when bus_held=1):
  - Q0: sda_oe=0, scl_oe unchanged
  - Q1: scl_oe=0
  - Q2: sda_oe=1 (SDA falls while SCL is high)
  - Q3: scl_oe=1
- STOP (executes even if bus_held=0):
  - Q0: scl_oe=1, sda_oe=1
  - Q1: scl_oe=0
  - Q2: sda_oe=0 (SDA rises while SCL is high)
  - Q3: hold
- BIT, for 9 bits (index 0..8):
  - Q0: scl_oe=1, drive SDA.
    - WRITE bits 0-7: wr_data MSB first, sda_oe = ~bit. Bit 8: release.
    - READ bits 0-7: release. Bit 8: sda_oe = ~rd_ack_in.
  - Q1: scl_oe=0.
  - Q2: SCL high. sda_in is sampled on the last clk of Q2, shifted MSB first into rd_data (READ bits 0-7) or captured into ack_rcvd (WRITE bit 8).
  - Q3: scl_oe=1.
  - After bit 8 Q3, SDA stays released and SCL stays low.
- Latency is measured from the acceptance cycle to the done cycle:
  - START/STOP: exactly 4*CLK_DIV+1 cycles
  - WRITE/READ: exactly 36*CLK_DIV+1 cycles
  - ERR (WRITE/READ with bus_held=0): done+err on the cycle after acceptance, no pin activity
- done and err are single-cycle pulses. err=0 for all normal completions.
- rd_data and ack_rcvd are updated only at the corresponding done. Partial shifts are not visible.
- Back-to-back: a new command may be accepted on the cycle after done, giving no idle gap on the bus.

Optional Feature:
- Macro I2C_GEN_STRETCH_EN.
- Defined: during Q2 of START, STOP and BIT, the quarter counter holds at 0 while scl_in=0 (slave clock stretching). Q2 runs its full CLK_DIV cycles after SCL is seen high, so latencies grow by the stretch length.
- Undefined: scl_in is unused and latencies are exact as above.

Test Plan:
- CLK_DIV=4; reset, START -> SDA falls while SCL high; done 17 cycles after accept; bus_held=1.
- START, WRITE 0xA5 with slave model ACKing -> SDA bits 1,0,1,0,0,1,0,1 stable across each SCL high; ack_rcvd=0; done 145 cycles after accept.
- START, READ with slave sending 0x3C, rd_ack_in=1 -> rd_data=0x3C; SDA released on 9th SCL high; then STOP -> SDA rises while SCL high, bus_held=0.
- WRITE with bus_held=0 -> done=1, err=1 the next cycle; scl_oe=sda_oe=0 throughout.
- Assert reset mid-WRITE (bit 4) -> next cycle scl_oe=0, sda_oe=0, cmd_ready=1, bus_held=0; a subsequent START completes normally.
- I2C_GEN_STRETCH_EN: slave holds scl_in low for 20 cycles in bit 2 -> WRITE done 165 cycles after accept, data correct.
